mem_arbiter: RTL and testbench

- Shares one single-port synchronous memory between the core's instruction-fetch port and data (load/store) port.
- Serialises accesses through an issue/wait/respond FSM.
- Returns read data to the winning requester with a one-cycle ack pulse.
- Sits between the mips core and a unified instruction/data RAM.

---
 rtl/mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises i-fetch and data accesses onto one sync RAM.
// Define MEM_ARB_RR_EN for round-robin ties instead of data priority.
module mem_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic        win_i_q, win_i_d;
  logic        we_q, we_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        i_ack_q, i_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        busy_q, busy_d;
  logic        grant_i;

`ifdef MEM_ARB_RR_EN
  logic        last_i_q, last_i_d;
`else
  logic [3:0]  starve_q, starve_d;
`endif

  // Tie-break: decide whether instruction wins this IDLE sample
  always_comb begin
`ifdef MEM_ARB_RR_EN
    grant_i = i_req & (~d_req | ~last_i_q);
`else
    grant_i = i_req &
      (~d_req | (starve_q == 4'(STARVE_MAX)));
`endif
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    win_i_d     = win_i_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef MEM_ARB_RR_EN
    last_i_d    = last_i_q;
`else
    starve_d    = starve_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d  = ISSUE;
          win_i_d  = grant_i;
          we_d     = ~grant_i & d_we;
          mem_en_d = 1'b1;
          mem_we_d = ~grant_i & d_we;
          if (grant_i) begin
            mem_addr_d = i_addr;
          end else begin
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end
`ifdef MEM_ARB_RR_EN
          last_i_d = grant_i;
`else
          if (grant_i) begin
            starve_d = '0;
          end else if (i_req &&
                       starve_q != 4'(STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
          end
`endif
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = RESP;
          d_ack_d = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = 3'(MEM_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = RESP;
          if (win_i_q) begin
            i_rdata_d = mem_rdata;
            i_ack_d   = 1'b1;
          end else begin
            d_rdata_d = mem_rdata;
            d_ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      win_i_q     <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_i_q    <= 1'b0;
`else
      starve_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      win_i_q     <= win_i_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
`ifdef MEM_ARB_RR_EN
      last_i_q    <= last_i_d;
`else
      starve_q    <= starve_d;
`endif
    end
  end

  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors and corner sequences for mem_arbiter.
// Memory model is a latency-LAT synchronous RAM.
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_ack, d_ack, mem_en, mem_we, busy;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata;

  mem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr),
    .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  logic        pv [LAT];
  logic [31:0] pa [LAT];
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    pv[0] <= mem_en & ~mem_we;
    pa[0] <= mem_addr;
    for (int k = 1; k < LAT; k++) begin
      pv[k] <= pv[k-1];
      pa[k] <= pa[k-1];
    end
  end

  assign mem_rdata = pv[LAT-1] ? mem[pa[LAT-1][9:2]] : 32'h0;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   viol    = 0;
  logic prev_en = 1'b0;

  always @(negedge clk) begin
    if (mem_en && prev_en) viol++;
    if (i_ack && d_ack) viol++;
    prev_en = mem_en;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  int          ack_cyc[$];
  int          ack_port[$];
  logic [31:0] ack_data[$];
  int          en_cyc[$];
  logic [31:0] en_addr[$];
  logic [31:0] en_wdata[$];
  logic        en_we[$];

  task automatic run(input bit hold, input int nack,
                     input int max_cyc);
    int t0;
    ack_cyc.delete(); ack_port.delete();
    ack_data.delete(); en_cyc.delete();
    en_addr.delete(); en_wdata.delete();
    en_we.delete();
    t0 = cyc;
    while (ack_cyc.size() < nack &&
           cyc - t0 < max_cyc) begin
      @(negedge clk);
      if (mem_en) begin
        en_cyc.push_back(cyc - t0);
        en_addr.push_back(mem_addr);
        en_we.push_back(mem_we);
        en_wdata.push_back(mem_wdata);
      end
      if (i_ack) begin
        ack_cyc.push_back(cyc - t0);
        ack_port.push_back(1);
        ack_data.push_back(i_rdata);
        if (hold) i_addr = i_addr + 32'd4;
        else i_req = 1'b0;
      end
      if (d_ack) begin
        ack_cyc.push_back(cyc - t0);
        ack_port.push_back(0);
        ack_data.push_back(d_rdata);
        if (!hold) d_req = 1'b0;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    chk("ack_count", ack_cyc.size(), nack);
    @(negedge clk);
    chk("busy_idle", busy, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit          is_i;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_ack;
  } vec_t;

  vec_t        v[7];
  logic [31:0] other;
  int          exp_order[6];

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
    for (int k = 0; k < LAT; k++) begin
      pv[k] = 1'b0;
      pa[k] = 32'h0;
    end
    mem[8'h40] = 32'h2409000A;
    mem[8'h02] = 32'h00001234;
    mem[8'h03] = 32'hCAFEF00D;
    mem[8'hFF] = 32'h80000001;

    v[0] = '{1, 0, 32'h100, 32'h0, 32'h2409000A, 4};
    v[1] = '{0, 1, 32'h40, 32'hDEADBEEF, 32'h0, 2};
    v[2] = '{0, 0, 32'h40, 32'h0, 32'hDEADBEEF, 4};
    v[3] = '{1, 0, 32'h8, 32'h0, 32'h00001234, 4};
    v[4] = '{0, 1, 32'h8, 32'h55AA55AA, 32'h0, 2};
    v[5] = '{1, 0, 32'h8, 32'h0, 32'h55AA55AA, 4};
    v[6] = '{0, 0, 32'hFFFFFFFC, 32'h0, 32'h80000001, 4};

    i_req = 0; d_req = 0; d_we = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_acks", {i_ack, d_ack}, 2'b00);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 7; n++) begin
      other = v[n].is_i ? d_rdata : i_rdata;
      if (v[n].is_i) begin
        i_req = 1'b1; i_addr = v[n].addr;
      end else begin
        d_req = 1'b1; d_we = v[n].we;
        d_addr = v[n].addr; d_wdata = v[n].wdata;
      end
      run(0, 1, 30);
      chk("v_en_count", en_cyc.size(), 1);
      chk("v_en_cyc", en_cyc[0], 1);
      chk("v_mem_addr", en_addr[0], v[n].addr);
      chk("v_mem_we", en_we[0], v[n].we);
      if (v[n].we)
        chk("v_mem_wdata", en_wdata[0], v[n].wdata);
      chk("v_ack_port", ack_port[0], v[n].is_i);
      chk("v_ack_cyc", ack_cyc[0], v[n].exp_ack);
      if (!v[n].we)
        chk("v_rdata", ack_data[0], v[n].exp_rdata);
      chk("v_other_hold",
          v[n].is_i ? d_rdata : i_rdata, other);
      d_we = 1'b0;
    end

    // Back-to-back instruction reads: acks LAT+3 apart
    i_req = 1'b1; i_addr = 32'h8;
    run(1, 2, 40);
    chk("b2b_ack0", ack_cyc[0], 4);
    chk("b2b_ack1", ack_cyc[1], 9);
    chk("b2b_data0", ack_data[0], 32'h55AA55AA);
    chk("b2b_data1", ack_data[1], 32'hCAFEF00D);

    // Simultaneous reads after reset
    do_reset();
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    run(0, 2, 40);
`ifdef MEM_ARB_RR_EN
    chk("tie_first", ack_port[0], 1);
    chk("tie_first_data", ack_data[0], 32'h2409000A);
`else
    chk("tie_first", ack_port[0], 0);
    chk("tie_first_data", ack_data[0], 32'h55AA55AA);
`endif
    chk("tie_ack0", ack_cyc[0], 4);
    chk("tie_en1", en_cyc[1], 6);
    chk("tie_ack1", ack_cyc[1], 9);

    // Both ports held: starvation guard / round-robin order
    do_reset();
`ifdef MEM_ARB_RR_EN
    exp_order = '{1, 0, 1, 0, 1, 0};
`else
    exp_order = '{0, 0, 0, 0, 1, 0};
`endif
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    run(1, 6, 100);
    for (int k = 0; k < 6; k++)
      chk($sformatf("order_%0d", k), ack_port[k],
          exp_order[k]);

    // Reset during WAIT discards the read
    do_reset();
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h100;
    @(negedge clk);
    chk("mid_issue_en", mem_en, 1'b1);
    @(negedge clk);
    chk("mid_wait_busy", busy, 1'b1);
    reset = 1'b1;
    i_req = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 1'b0);
    chk("mid_acks", {i_ack, d_ack}, 2'b00);
    chk("mid_mem_en", mem_en, 1'b0);
    chk("mid_i_rdata", i_rdata, 32'h0);
    chk("mid_mem_addr", mem_addr, 32'h0);
    reset = 1'b0;
    other = 0;
    repeat (8) begin
      @(negedge clk);
      if (i_ack || d_ack || busy) other = other + 1;
    end
    chk("mid_no_ack", other, 32'h0);

    chk("protocol_viol", viol, 0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
